// File: rtl/feeder_pkg.sv
// Shared types and helpers for the systolic edge feeder: FSM states,
// flush length and lane slice arithmetic.
package feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Drain time for the last vector to walk from lane 0 to the far-corner PE.
  function automatic int flush_len(input int lanes);
    return 2 * (lanes - 1) + 1;
  endfunction

  function automatic int lane_lo(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register delay line for one skewed lane; shifts every cycle.
module skew_delay_line #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skewed edge feeder for the systolic MAC array: lane i lags lane 0 by i cycles.
// Optional bubble counter built only when FEEDER_STALL_CNT_EN is defined.
module systolic_skew_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int K_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [K_WIDTH-1:0]          k_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic [LANES*DATA_WIDTH-1:0] lane_out,
  output logic                        acc_clr,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 stall_cnt
);

  localparam int FLUSH_LEN = flush_len(LANES);
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  state_e             state_q, state_d;
  logic [K_WIDTH-1:0] klen_q, klen_d;
  logic [K_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic               accept;

  assign accept  = in_valid && (state_q == ST_STREAM);
  assign cnt_inc = cnt_q + K_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      klen_q  <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          klen_d  = k_len;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = (klen_q == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == klen_q) begin
            fcnt_d  = '0;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == FW'(FLUSH_LEN - 1)) state_d = ST_DONE;
        else                              fcnt_d  = fcnt_q + FW'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pure decodes of the state register, so no input reaches these outputs.
  assign in_ready = (state_q == ST_STREAM);
  assign acc_clr  = (state_q == ST_CLEAR);
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);

  // Bubbles inject zeros so x*w contributes nothing on either edge.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_d;
    assign lane_d = accept ? in_data[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] : '0;
    skew_delay_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (i + 1)
    ) u_dl (
      .clk(clk),
      .rst(rst),
      .d_i(lane_d),
      .q_o(lane_out[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start)
      stall_d = '0;
    else if (state_q == ST_STREAM && !in_valid && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed table-driven bench for systolic_skew_feeder (LANES=4, DATA_WIDTH=32).
module tb_systolic_skew_feeder;

  localparam int DW = 32;
  localparam int NL = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [15:0]        k_len;
  logic               in_valid;
  logic               in_ready;
  logic [NL*DW-1:0]   in_data;
  logic [NL*DW-1:0]   lane_out;
  logic               acc_clr;
  logic               busy;
  logic               done;
  logic [15:0]        stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .LANES(NL), .K_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .lane_out (lane_out),
    .acc_clr  (acc_clr),
    .busy     (busy),
    .done     (done),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ga/gl: gap of gl idle cycles after ga vectors; bs_c: cycle of a busy start;
  // rst_c: cycle of a mid-tile reset; e0: last accept edge; dn: done cycle.
  typedef struct {
    int k;
    int ga;
    int gl;
    int base;
    int bs_c;
    int rst_c;
    int e0;
    int dn;
  } vec_t;

  vec_t tbl [8];
  logic [NL-1:0][DW-1:0] hist [0:40];

  task automatic chk(input string name, input int c, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
    end
  endtask

  function automatic logic [NL*DW-1:0] mkvec(input int base, input int vi);
    logic [NL*DW-1:0] v;
    for (int l = 0; l < NL; l++) v[l*DW +: DW] = DW'(base + vi * 16 + l + 1);
    return v;
  endfunction

  task automatic run(input vec_t t);
    int vi, gd, exp_stall;
    logic acc;
    logic [NL-1:0][DW-1:0] ev;
`ifdef FEEDER_STALL_CNT_EN
    exp_stall = t.gl;
`else
    exp_stall = 0;
`endif
    for (int j = 0; j <= 40; j++) hist[j] = '0;
    vi = 0;
    gd = 0;
    start    = 1'b1;
    k_len    = 16'(t.k);
    in_valid = 1'b0;
    for (int c = 0; c <= t.dn + 2; c++) begin
      @(negedge clk);
      start = (c == t.bs_c);
      if (c == t.bs_c) k_len = 16'd9;
      chk("acc_clr", c, 128'(acc_clr), 128'(c == 0));
      chk("in_ready", c, 128'(in_ready), 128'(c >= 1 && c < t.e0));
      chk("busy", c, 128'(busy), 128'(c <= t.dn));
      chk("done", c, 128'(done), 128'(c == t.dn));
      for (int i = 0; i < NL; i++) ev[i] = (c - i >= 0) ? hist[c-i][i] : '0;
      chk("lane_out", c, 128'(lane_out), 128'(ev));
      if (c == t.dn + 1) chk("stall_cnt", c, 128'(stall_cnt), 128'(exp_stall));
      if (c == t.rst_c) begin
        rst = 1'b1;
        #1;
        chk("rst_lane_out", c, 128'(lane_out), 128'(0));
        chk("rst_busy", c, 128'(busy), 128'(0));
        chk("rst_in_ready", c, 128'(in_ready), 128'(0));
        chk("rst_acc_done", c, 128'({acc_clr, done}), 128'(0));
        chk("rst_stall", c, 128'(stall_cnt), 128'(0));
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        return;
      end
      in_valid = (vi < t.k) && !(vi == t.ga && gd < t.gl);
      in_data  = mkvec(t.base, vi);
      acc      = in_valid && in_ready;
      if (in_ready && !in_valid) gd++;
      hist[c+1] = acc ? in_data : '0;
      if (acc) vi++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    chk("reset_lane_out", 0, 128'(lane_out), 128'(0));
    chk("reset_ctrl", 0, 128'({in_ready, acc_clr, busy, done}), 128'(0));
    chk("reset_stall", 0, 128'(stall_cnt), 128'(0));
    #1 rst = 1'b0;

    tbl[0] = '{1, 0, 0, 0,            -1, -1, 2, 9};   // single vector {1,2,3,4}
    tbl[1] = '{3, 1, 2, 32'h100,      -1, -1, 6, 13};  // 2-cycle stall
    tbl[2] = '{3, 0, 0, 32'h200,      -1, -1, 4, 11};  // same tile, no stall
    tbl[3] = '{0, 0, 0, 0,            -1, -1, 0, 1};   // empty tile
    tbl[4] = '{4, 0, 0, 32'h300,      -1,  3, 5, 12};  // reset after 2 of 4
    tbl[5] = '{4, 0, 0, 32'h400,      -1, -1, 5, 12};  // full tile after reset
    tbl[6] = '{2, 0, 0, 32'h500,       6, -1, 3, 10};  // start during FLUSH
    tbl[7] = '{5, 3, 3, 32'hA0000000, -1, -1, 9, 16};  // late 3-cycle stall

    @(negedge clk);
    for (int n = 0; n < 8; n++) run(tbl[n]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Edge feeder for the systolic MAC array. It accepts one packed LANES-wide operand vector per cycle from the tile buffer and drives the array edge with diagonally skewed lanes: lane i is delayed i cycles relative to lane 0. It also emits the accumulator-clear pulse and a `done` strobe once the far-corner PE has absorbed the last product. Two instances, one for the x edge and one for the w edge, share `start`/`in_valid`, so stall bubbles stay aligned.

## Interface
- `DATA_WIDTH`, 32, element width.
- `LANES`, 4, array dimension N; number of skewed lanes.
- `K_WIDTH`, 16, width of the vector-count field.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle request to begin a tile; ignored unless in IDLE.
- `k_len`  in  K_WIDTH  number of vectors in the tile; sampled with `start`.
- `in_valid`  in  1  upstream vector valid.
- `in_ready`  out  1  high only in STREAM.
- `in_data`  in  LANES*DATA_WIDTH  vector; lane i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `lane_out`  out  LANES*DATA_WIDTH  skewed edge data to the array, same packing.
- `acc_clr`  out  1  one-cycle accumulator clear; the array top drives PE reset from this.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle strobe; array results are final.
- `stall_cnt`  out  16  bubble counter (see Configuration).

## Operation
- FSM states: IDLE, CLEAR, STREAM, FLUSH, DONE.
  - IDLE: on `start`, latch `k_len` and go to CLEAR.
  - CLEAR: lasts 1 cycle with `acc_clr`=1. Next state is STREAM, or DONE if `k_len`==0.
  - STREAM: a vector is accepted on each edge where `in_valid && in_ready`. Lane-0 input is `in_data` on accept, otherwise 0 (bubble). Go to FLUSH on the edge that accepts vector `k_len`.
  - FLUSH: lasts exactly 2*(LANES-1)+1 cycles. Lane-0 input is 0. Then go to DONE.
  - DONE: lasts 1 cycle with `done`=1. Then go to IDLE.
- Skew: lane i is a registered delay line of depth i+1. An element accepted at edge E appears on lane i after edge E+i.
- All delay lines shift every cycle in every state; the feeder never freezes the array.
- Bubbles are zero on both edges (shared `in_valid`), so x*w=0 and accumulation is unaffected.
- The vector counter counts accepted vectors only. It is compared with the latched `k_len`, using unsigned arithmetic at K_WIDTH.
- `start` while `busy` is dropped and has no side effect. `k_len` changes outside IDLE are ignored.

## Timing
- Reset values: `lane_out`=0, `in_ready`=0, `acc_clr`=0, `busy`=0, `done`=0, `stall_cnt`=0, state IDLE, counters 0.
- Reset mid-tile: all outputs return to reset values immediately (async); the next `start` runs a full tile.
- Start-to-stream: `start` at edge S, `acc_clr` high during cycle S..S+1, `in_ready` high from edge S+1.
- Final y latency: last vector accepted at edge E0. PE(r,c) last accumulates at edge E0+r+c+1. The far corner finishes at E0+2*LANES-1.
- `done` is high in the cycle following edge E0+2*(LANES-1)+1.
- For `k_len`==0, `done` is high in the second cycle after `start`.
- `in_ready` deasserts on the same edge that accepts the final vector. No over-accept is possible.
- `acc_clr`, `done` and `in_ready` are registered state decodes, with no combinational path from inputs.

## Configuration
- `FEEDER_STALL_CNT_EN` defined:
  - `stall_cnt` counts STREAM cycles with `in_valid`=0 and saturates at 16'hFFFF.
  - It clears on entering CLEAR and holds its value after DONE.
- Not defined: `stall_cnt` is tied to 0 and no counter logic is built. The port stays present so the interface is stable.

## Structure
- Shared package `feeder_pkg`:
  - FSM state typedef (IDLE, CLEAR, STREAM, FLUSH, DONE).
  - Function computing flush length 2*(LANES-1)+1 from LANES.
  - Lane slice index helper.
- Sub-module `skew_delay_line`: parameters DATA_WIDTH and DEPTH; async active-high reset to 0. It is instantiated once per lane with DEPTH = i+1 via generate.

## Test plan
All tests use LANES=4 and DATA_WIDTH=32.
- Reset: assert `rst` with no clock. All outputs are 0, `in_ready`=0 and `busy`=0.
- Single vector: `k_len`=1 and `in_data` lanes {1,2,3,4} (lane0=1), accepted at edge E0.
  - lane0=1 after E0, lane3=4 after E0+3, and all lanes are 0 after that.
  - `done` is high exactly in the cycle after edge E0+7.
- Stall: `k_len`=3 with `in_valid` low for 2 cycles between vectors 1 and 2.
  - Two zero bubbles appear on lane0, and `done` is delayed by 2 cycles compared with the no-stall run.
  - `stall_cnt`=2 with the macro defined, and 0 without it.
- `k_len`=0: `acc_clr` pulses once, `in_ready` never rises, and `done` pulses in the second cycle after `start`.
- Reset mid-STREAM: assert `rst` after 2 of 4 vectors.
  - `lane_out`=0 and `busy`=0 immediately.
  - A subsequent `start` with `k_len`=4 completes with correct timing.
- Busy start: pulse `start` with `k_len`=9 during FLUSH. It is ignored, no extra `acc_clr` pulse occurs, and `done` timing is unchanged.
